// File: rtl/rgb2hsv_pkg.sv
// ============================================================================
// Module      : rgb2hsv_pkg
// Description : Shared channel indices, sector bases and latency formula
//               for the RGB-to-HSV pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rgb2hsv_pkg;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } ch_e;

    // Hue sector base, in units of HUE_SECT, for each max channel
    localparam int SECT_MUL_R = 0;
    localparam int SECT_MUL_G = 2;
    localparam int SECT_MUL_B = 4;

    function automatic int lat_of(input int dw);
        return dw + 3;
    endfunction

    function automatic int sect_base(input ch_e ch, input int hue_sect);
        case (ch)
            CH_G:    return SECT_MUL_G * hue_sect;
            CH_B:    return SECT_MUL_B * hue_sect;
            default: return SECT_MUL_R * hue_sect;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/hsv_div_pipe.sv
// ============================================================================
// Module      : hsv_div_pipe
// Description : DW-stage pipelined restoring divider, one quotient bit per
//               stage (MSB first); a zero flag travels alongside and forces 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hsv_div_pipe #(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2*DW-1:0]   dividend,
    input  logic [DW-1:0]     divisor,
    input  logic              zero_in,
    output logic [DW-1:0]     quotient,
    output logic              zero_out
);

    logic [2*DW-1:0] r_rem [1:DW];
    logic [DW-1:0]   r_div [1:DW];
    logic [DW-1:0]   r_q   [1:DW];
    logic            r_zf  [1:DW];

    logic [2*DW-1:0] w_rem_in [0:DW-1];
    logic [DW-1:0]   w_div_in [0:DW-1];
    logic [DW-1:0]   w_q_in   [0:DW-1];
    logic            w_zf_in  [0:DW-1];
    logic [2*DW-1:0] w_sh     [0:DW-1];
    logic            w_ge     [0:DW-1];
    logic [2*DW-1:0] w_rem_nx [0:DW-1];

    // Stage s decides quotient bit DW-1-s against the divisor shifted up by that bit
    always_comb begin
        for (int s = 0; s < DW; s++) begin
            if (s == 0) begin
                w_rem_in[s] = dividend;
                w_div_in[s] = divisor;
                w_q_in[s]   = '0;
                w_zf_in[s]  = zero_in;
            end else begin
                w_rem_in[s] = r_rem[s];
                w_div_in[s] = r_div[s];
                w_q_in[s]   = r_q[s];
                w_zf_in[s]  = r_zf[s];
            end
            w_sh[s]     = {{DW{1'b0}}, w_div_in[s]} << (DW - 1 - s);
            w_ge[s]     = (w_rem_in[s] >= w_sh[s]);
            w_rem_nx[s] = w_ge[s] ? (w_rem_in[s] - w_sh[s]) : w_rem_in[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 1; s <= DW; s++) begin
                r_rem[s] <= '0;
                r_div[s] <= '0;
                r_q[s]   <= '0;
                r_zf[s]  <= 1'b0;
            end
        end else begin
            for (int s = 0; s < DW; s++) begin
                r_rem[s+1] <= w_rem_nx[s];
                r_div[s+1] <= w_div_in[s];
                r_q[s+1]   <= {w_q_in[s][DW-2:0], w_ge[s]};
                r_zf[s+1]  <= w_zf_in[s];
            end
        end
    end

    assign quotient = r_zf[DW] ? '0 : r_q[DW];
    assign zero_out = r_zf[DW];

endmodule

`default_nettype wire

// File: rtl/rgb2hsv_pipe.sv
// ============================================================================
// Module      : rgb2hsv_pipe
// Description : Fully pipelined RGB-to-HSV converter, one pixel per clock,
//               fixed latency DW+3 with syncs delayed to match.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb2hsv_pipe
    import rgb2hsv_pkg::*;
#(
    parameter int DW       = 8,
    parameter int HUE_SECT = 42,
    parameter int SAT_MODE = 1,
    parameter int HUE_EN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_hs,
    input  logic              in_vs,
    input  logic              in_de,
    input  logic [3*DW-1:0]   in_rgb,
    output logic              hsv_hs,
    output logic              hsv_vs,
    output logic              hsv_de,
    output logic [3*DW-1:0]   hsv
);

    localparam int              c_lat       = lat_of(DW);
    localparam logic [DW+1:0]   c_hue_full  = (DW+2)'(6 * HUE_SECT);
    localparam logic [2*DW-1:0] c_hue_scale = (2*DW)'(HUE_SECT);
    localparam logic [2*DW-1:0] c_sat_scale = (2*DW)'((2**DW) - 1);

    // Stage 1: max/min select and signed hue numerator
    logic [DW-1:0]   w_r, w_g, w_b, w_max, w_min, w_min_rg;
    logic signed [DW:0] w_num;
    ch_e             w_idx;

    assign w_r      = in_rgb[3*DW-1:2*DW];
    assign w_g      = in_rgb[2*DW-1:DW];
    assign w_b      = in_rgb[DW-1:0];
    assign w_min_rg = (w_r < w_g) ? w_r : w_g;
    assign w_min    = (w_min_rg < w_b) ? w_min_rg : w_b;

    always_comb begin
        w_idx = CH_R;
        w_max = w_r;
        w_num = $signed({1'b0, w_g}) - $signed({1'b0, w_b});
        if (w_r >= w_g && w_r >= w_b) begin
            w_idx = CH_R;
            w_max = w_r;
            w_num = $signed({1'b0, w_g}) - $signed({1'b0, w_b});
        end else if (w_g >= w_b) begin
            w_idx = CH_G;
            w_max = w_g;
            w_num = $signed({1'b0, w_b}) - $signed({1'b0, w_r});
        end else begin
            w_idx = CH_B;
            w_max = w_b;
            w_num = $signed({1'b0, w_r}) - $signed({1'b0, w_g});
        end
    end

    logic [DW-1:0]      r1_max, r1_min;
    logic signed [DW:0] r1_num;
    ch_e                r1_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_max <= '0;
            r1_min <= '0;
            r1_num <= '0;
            r1_idx <= CH_R;
        end else begin
            r1_max <= w_max;
            r1_min <= w_min;
            r1_num <= w_num;
            r1_idx <= w_idx;
        end
    end

    // Stage 2: delta and divider operands
    logic [DW-1:0]   w_delta;
    logic [DW:0]     w_abs;
    logic [2*DW-1:0] r2_hue_dvd, r2_sat_dvd;
    logic [DW-1:0]   r2_delta, r2_max, r2_base;
    logic            r2_neg, r2_hue_zf, r2_sat_zf;

    assign w_delta = r1_max - r1_min;
    assign w_abs   = r1_num[DW] ? -r1_num : r1_num;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_hue_dvd <= '0;
            r2_sat_dvd <= '0;
            r2_delta   <= '0;
            r2_max     <= '0;
            r2_base    <= '0;
            r2_neg     <= 1'b0;
            r2_hue_zf  <= 1'b0;
            r2_sat_zf  <= 1'b0;
        end else begin
            r2_hue_dvd <= (2*DW)'(w_abs) * c_hue_scale;
            r2_sat_dvd <= (2*DW)'(w_delta) * c_sat_scale;
            r2_delta   <= w_delta;
            r2_max     <= r1_max;
            r2_base    <= DW'(sect_base(r1_idx, HUE_SECT));
            r2_neg     <= r1_num[DW];
            r2_hue_zf  <= (w_delta == '0);
            r2_sat_zf  <= (r1_max == '0);
        end
    end

    // Sign, sector base and value ride alongside the dividers
    logic [2*DW:0] r_side [1:DW];
    logic [2:0]    r_sync [1:c_lat];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= DW; i++)    r_side[i] <= '0;
            for (int i = 1; i <= c_lat; i++) r_sync[i] <= '0;
        end else begin
            r_side[1] <= {r2_neg, r2_base, r2_max};
            for (int i = 2; i <= DW; i++)    r_side[i] <= r_side[i-1];
            r_sync[1] <= {in_hs, in_vs, in_de};
            for (int i = 2; i <= c_lat; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    logic          w_neg;
    logic [DW-1:0] w_base, w_val, w_hue, w_sat;

    assign w_neg  = r_side[DW][2*DW];
    assign w_base = r_side[DW][2*DW-1:DW];
    assign w_val  = r_side[DW][DW-1:0];

    if (HUE_EN != 0) begin : g_hue
        logic [DW-1:0] w_q;
        logic          w_zf;
        logic [DW+1:0] w_h_raw;

        hsv_div_pipe #(.DW(DW)) u_hue_div (
            .clk      (clk),
            .rst_n    (rst_n),
            .dividend (r2_hue_dvd),
            .divisor  (r2_delta),
            .zero_in  (r2_hue_zf),
            .quotient (w_q),
            .zero_out (w_zf)
        );

        // Negative offsets are lifted by one full turn so the subtraction never underflows
        assign w_h_raw = w_neg ? ({2'b00, w_base} + c_hue_full - {2'b00, w_q})
                               : ({2'b00, w_base} + {2'b00, w_q});
        assign w_hue   = (w_h_raw >= c_hue_full) ? DW'(w_h_raw - c_hue_full) : DW'(w_h_raw);
    end else begin : g_no_hue
        assign w_hue = '0;
    end

    if (SAT_MODE != 0) begin : g_sat_div
        logic w_zf;

        hsv_div_pipe #(.DW(DW)) u_sat_div (
            .clk      (clk),
            .rst_n    (rst_n),
            .dividend (r2_sat_dvd),
            .divisor  (r2_max),
            .zero_in  (r2_sat_zf),
            .quotient (w_sat),
            .zero_out (w_zf)
        );
    end else begin : g_sat_raw
        logic [DW-1:0] r_dly [1:DW];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 1; i <= DW; i++) r_dly[i] <= '0;
            end else begin
                r_dly[1] <= r2_delta;
                for (int i = 2; i <= DW; i++) r_dly[i] <= r_dly[i-1];
            end
        end

        assign w_sat = r_dly[DW];
    end

    logic [3*DW-1:0] r_hsv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsv <= '0;
        end else begin
            r_hsv <= r_sync[c_lat-1][0] ? {w_hue, w_sat, w_val} : '0;
        end
    end

    assign hsv    = r_hsv;
    assign hsv_hs = r_sync[c_lat][2];
    assign hsv_vs = r_sync[c_lat][1];
    assign hsv_de = r_sync[c_lat][0];

endmodule

`default_nettype wire

// File: tb/tb_rgb2hsv_pipe.sv
// ============================================================================
// Module      : tb_rgb2hsv_pipe
// Description : Self-checking bench for rgb2hsv_pipe (normalised and raw
//               saturation instances driven from the same stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb2hsv_pipe;

    localparam int DW  = 8;
    localparam int H   = 42;
    localparam int LAT = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_hs, in_vs, in_de;
    logic [23:0] in_rgb;
    logic        hs1, vs1, de1, hs0, vs0, de0;
    logic [23:0] hsv1, hsv0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rgb2hsv_pipe #(.DW(DW), .HUE_SECT(H), .SAT_MODE(1), .HUE_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .in_rgb(in_rgb),
        .hsv_hs(hs1), .hsv_vs(vs1), .hsv_de(de1), .hsv(hsv1)
    );

    rgb2hsv_pipe #(.DW(DW), .HUE_SECT(H), .SAT_MODE(0), .HUE_EN(1)) u_dut_raw (
        .clk(clk), .rst_n(rst_n), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .in_rgb(in_rgb),
        .hsv_hs(hs0), .hsv_vs(vs0), .hsv_de(de0), .hsv(hsv0)
    );

    // Reference conversion straight from the colour-space definition
    function automatic logic [23:0] ref_hsv(input logic [23:0] rgb, input bit raw_sat);
        int r, g, b, mx, mn, num, base, delta, q, hue, sat;
        r = int'(rgb[23:16]);
        g = int'(rgb[15:8]);
        b = int'(rgb[7:0]);
        if (r >= g && r >= b) begin
            mx = r; num = g - b; base = 0;
        end else if (g >= b) begin
            mx = g; num = b - r; base = 2 * H;
        end else begin
            mx = b; num = r - g; base = 4 * H;
        end
        mn    = (r < g) ? r : g;
        mn    = (mn < b) ? mn : b;
        delta = mx - mn;
        q     = (delta == 0) ? 0 : (((num < 0) ? -num : num) * H) / delta;
        hue   = (num < 0) ? base - q : base + q;
        hue   = ((hue % (6 * H)) + 6 * H) % (6 * H);
        if (raw_sat) sat = delta;
        else         sat = (mx == 0) ? 0 : (delta * 255) / mx;
        return {8'(hue), 8'(sat), 8'(mx)};
    endfunction

    task automatic drive(input logic hs, input logic vs, input logic de, input logic [23:0] rgb);
        in_hs  = hs;
        in_vs  = vs;
        in_de  = de;
        in_rgb = rgb;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 24'hffffff);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({hs1, vs1, de1, hsv1} !== 27'd0) begin
                n_errors++;
                $display("FAIL reset_norm cycle %0d: got %h, expected 0", i, {hs1, vs1, de1, hsv1});
            end
            n_checks++;
            if ({hs0, vs0, de0, hsv0} !== 27'd0) begin
                n_errors++;
                $display("FAIL reset_raw cycle %0d: got %h, expected 0", i, {hs0, vs0, de0, hsv0});
            end
        end
        drive(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic test_known();
        logic [23:0] pix  [7] = '{24'hff0000, 24'h00ff00, 24'h0000ff, 24'h808080,
                                 24'h000000, 24'hff0080, 24'hc86432};
        logic [23:0] exp1 [7] = '{24'h00ffff, 24'h54ffff, 24'ha8ffff, 24'h000080,
                                 24'h000000, 24'he7ffff, 24'h0ebfc8};
        logic [23:0] exp0 [7] = '{24'h00ffff, 24'h54ffff, 24'ha8ffff, 24'h000080,
                                 24'h000000, 24'he7ffff, 24'h0e96c8};
        logic [23:0] e1, e0;
        logic [2:0]  es;
        for (int i = 0; i < 7 + LAT; i++) begin
            @(posedge clk); #1;
            e1 = 24'd0; e0 = 24'd0; es = 3'b000;
            if (i >= LAT) begin
                e1 = exp1[i-LAT]; e0 = exp0[i-LAT]; es = 3'b001;
            end
            n_checks++;
            if (hsv1 !== e1) begin
                n_errors++;
                $display("FAIL known_norm cycle %0d: got %h, expected %h", i, hsv1, e1);
            end
            n_checks++;
            if (hsv0 !== e0) begin
                n_errors++;
                $display("FAIL known_raw cycle %0d: got %h, expected %h", i, hsv0, e0);
            end
            n_checks++;
            if ({hs1, vs1, de1} !== es) begin
                n_errors++;
                $display("FAIL known_sync cycle %0d: got %b, expected %b", i, {hs1, vs1, de1}, es);
            end
            if (i < 7) drive(1'b0, 1'b0, 1'b1, pix[i]);
            else       drive(1'b0, 1'b0, 1'b0, 24'h0);
        end
    endtask

    task automatic test_sync_pulses();
        logic [2:0]  es;
        logic [23:0] e1, e0;
        int k;
        for (int i = 0; i < 12 + LAT; i++) begin
            @(posedge clk); #1;
            k  = i - LAT;
            es = {k == 2, k == 5, k == 8};
            e1 = (k == 8) ? 24'h0ebfc8 : 24'd0;
            e0 = (k == 8) ? 24'h0e96c8 : 24'd0;
            n_checks++;
            if ({hs1, vs1, de1, hs0, vs0, de0} !== {es, es}) begin
                n_errors++;
                $display("FAIL sync_pulse cycle %0d: got %b, expected %b", i,
                         {hs1, vs1, de1, hs0, vs0, de0}, {es, es});
            end
            n_checks++;
            if ({hsv1, hsv0} !== {e1, e0}) begin
                n_errors++;
                $display("FAIL sync_pixel cycle %0d: got %h, expected %h", i, {hsv1, hsv0}, {e1, e0});
            end
            if (i < 12) drive(i == 2, i == 5, i == 8, (i == 8) ? 24'hc86432 : 24'($urandom));
            else        drive(1'b0, 1'b0, 1'b0, 24'h0);
        end
    endtask

    task automatic test_de_gating();
        logic [2:0] hist [16];
        logic [2:0] es;
        for (int i = 0; i < 16 + LAT; i++) begin
            @(posedge clk); #1;
            es = (i >= LAT) ? hist[i-LAT] : 3'b000;
            n_checks++;
            if ({hsv1, hsv0} !== 48'd0) begin
                n_errors++;
                $display("FAIL de_gate cycle %0d: got %h, expected 0", i, {hsv1, hsv0});
            end
            n_checks++;
            if ({hs1, vs1, de1} !== es) begin
                n_errors++;
                $display("FAIL de_gate_sync cycle %0d: got %b, expected %b", i, {hs1, vs1, de1}, es);
            end
            if (i < 16) begin
                hist[i] = {1'($urandom), 1'($urandom), 1'b0};
                drive(hist[i][2], hist[i][1], 1'b0, 24'($urandom) | 24'h010101);
            end else begin
                drive(1'b0, 1'b0, 1'b0, 24'h0);
            end
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 150;
        logic [2:0]  hs_q [N];
        logic [23:0] e1_q [N];
        logic [23:0] e0_q [N];
        logic [2:0]  es;
        logic [23:0] e1, e0, rgb;
        logic        de;
        for (int i = 0; i < N + LAT; i++) begin
            @(posedge clk); #1;
            es = 3'b000; e1 = 24'd0; e0 = 24'd0;
            if (i >= LAT) begin
                es = hs_q[i-LAT]; e1 = e1_q[i-LAT]; e0 = e0_q[i-LAT];
            end
            n_checks++;
            if ({hs1, vs1, de1, hs0, vs0, de0} !== {es, es}) begin
                n_errors++;
                $display("FAIL b2b_sync cycle %0d: got %b, expected %b", i,
                         {hs1, vs1, de1, hs0, vs0, de0}, {es, es});
            end
            n_checks++;
            if (hsv1 !== e1) begin
                n_errors++;
                $display("FAIL b2b_norm cycle %0d: got %h, expected %h", i, hsv1, e1);
            end
            n_checks++;
            if (hsv0 !== e0) begin
                n_errors++;
                $display("FAIL b2b_raw cycle %0d: got %h, expected %h", i, hsv0, e0);
            end
            if (i < N) begin
                rgb = 24'($urandom);
                case ($urandom_range(0, 4))
                    1: rgb[15:8] = rgb[23:16];
                    2: rgb[7:0]  = rgb[15:8];
                    3: rgb = {3{rgb[7:0]}};
                    default: ;
                endcase
                de = ($urandom_range(0, 7) != 0);
                hs_q[i] = {1'($urandom), 1'($urandom), de};
                e1_q[i] = de ? ref_hsv(rgb, 1'b0) : 24'd0;
                e0_q[i] = de ? ref_hsv(rgb, 1'b1) : 24'd0;
                drive(hs_q[i][2], hs_q[i][1], de, rgb);
            end else begin
                drive(1'b0, 1'b0, 1'b0, 24'h0);
            end
        end
    endtask

    task automatic test_reset_midstream();
        localparam int N = 20;
        logic [23:0] pix  [N];
        logic [23:0] e1, e0;
        logic [2:0]  es;
        for (int i = 0; i < LAT + 3; i++) begin
            @(posedge clk); #1;
            drive(1'b1, 1'b1, 1'b1, 24'($urandom) | 24'h800000);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({hs1, vs1, de1, hsv1, hs0, vs0, de0, hsv0} !== 54'd0) begin
            n_errors++;
            $display("FAIL async_reset: got %h, expected 0", {hs1, vs1, de1, hsv1, hs0, vs0, de0, hsv0});
        end
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N + LAT; i++) begin
            @(posedge clk); #1;
            es = 3'b000; e1 = 24'd0; e0 = 24'd0;
            if (i >= LAT) begin
                es = 3'b001;
                e1 = ref_hsv(pix[i-LAT], 1'b0);
                e0 = ref_hsv(pix[i-LAT], 1'b1);
            end
            n_checks++;
            if ({hs1, vs1, de1, hs0, vs0, de0} !== {es, es}) begin
                n_errors++;
                $display("FAIL post_reset_sync cycle %0d: got %b, expected %b", i,
                         {hs1, vs1, de1, hs0, vs0, de0}, {es, es});
            end
            n_checks++;
            if ({hsv1, hsv0} !== {e1, e0}) begin
                n_errors++;
                $display("FAIL post_reset_pixel cycle %0d: got %h, expected %h", i, {hsv1, hsv0}, {e1, e0});
            end
            if (i < N) begin
                pix[i] = 24'($urandom);
                drive(1'b0, 1'b0, 1'b1, pix[i]);
            end else begin
                drive(1'b0, 1'b0, 1'b0, 24'h0);
            end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        rst_n = 1'b0;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_known();
        test_sync_pulses();
        test_de_gating();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
